enum_stepper: RTL and testbench
===============================

# enum_stepper

Hardware model of SystemVerilog enum semantics over a parameterised table of legal codes of arbitrary width. It holds a current enum value and executes cast (`$cast`), forced assignment (`T'(x)`) and multi-step `next(k)`/`prev(k)` commands with wrap-around. Each command uses a valid/ready request and a one-cycle response. The block serves as a synthesizable reference and regression target for wide-enum method handling in generated code, and generalises the fixed two-member, 60-bit case to any width, member count and step count.

## Interface
Parameters:
- WIDTH, 60: code width in bits; legal range 1..128.
- COUNT, 3: number of enum members; minimum 2.
- CODES, {60'hFFF, 60'h1234_4567_abcd, 60'h1}: packed COUNT*WIDTH member table; member i is CODES[i*WIDTH +: WIDTH].
- STEPW, 8: width of the step count.
- IW, $clog2(COUNT): index width.

Ports:
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command request.
- cmd_ready, output, 1: command accept.
- cmd_op, input, 2: 00 SET (cast), 01 NEXT, 10 PREV, 11 FORCE.
- cmd_arg, input, WIDTH: value for SET/FORCE; bits [STEPW-1:0] are the step count k for NEXT/PREV.
- value, output, WIDTH: current enum value.
- index, output, IW: member index of value; 0 when unknown.
- known, output, 1: value equals some member.
- rsp_valid, output, 1: one-cycle completion pulse.
- rsp_ok, output, 1: command success; valid only with rsp_valid.

## Operation
- A command is accepted on an edge where cmd_valid && cmd_ready.
- FSM states:
  - IDLE: cmd_ready=1. It moves to STEP on an accepted NEXT/PREV with known=1 and k>0. All other accepted commands complete in IDLE.
  - STEP: cmd_ready=0. Each edge advances the index by ±1, modulo COUNT, and decrements a remaining-step counter. After the last step the FSM returns to IDLE and raises rsp_valid.
- Lookup compares against all members in parallel. With duplicate codes the lowest index wins.
- SET:
  - If the argument is a member: value=arg, index=match, known=1, rsp_ok=1.
  - Otherwise: state unchanged, rsp_ok=0.
- FORCE:
  - value=arg unconditionally.
  - known and index come from the lookup, with index=0 when there is no match.
  - rsp_ok=known.
- NEXT/PREV with known=1:
  - Wraps: index COUNT-1 +1 gives 0, and 0 -1 gives COUNT-1.
  - k ≥ COUNT is legal and wraps repeatedly.
  - k=0 leaves the state unchanged.
  - rsp_ok=1.
- NEXT/PREV with known=0: state unchanged, rsp_ok=0, completes in one cycle regardless of k.
- value always equals CODES[index] while known=1. value updates once per step, so intermediate members are visible during STEP.
- Arithmetic: the index step is modulo COUNT and must be correct for COUNT values that are not powers of two. All WIDTH bits are compared, with no truncation to 32 or 64 bits.

## Timing
- Reset (rst high at an edge):
  - value=CODES[0], index=0, known=1.
  - rsp_valid=0, rsp_ok=0.
  - FSM returns to IDLE.
  - cmd_ready=0 while rst is high.
- Reset mid-STEP aborts the command and produces no response.
- Latency:
  - SET, FORCE, NEXT/PREV with k=0, and NEXT/PREV on an unknown value: rsp_valid in the cycle after acceptance.
  - NEXT/PREV with k>0: rsp_valid in cycle k+1 after acceptance.
- rsp_valid is high for exactly one cycle. value, index and known already show final results in that cycle.
- cmd_ready is high during the rsp_valid cycle, so back-to-back commands are allowed. A command accepted in the response cycle does not disturb that response.
- cmd_valid while cmd_ready=0 is ignored; the requester holds the command.

## Test plan
(Defaults: E0=60'h1, E1=60'h1234_4567_abcd, E2=60'hFFF.)
- **Reset:** pulse rst -> value=60'h1, index=0, known=1, rsp_valid=0, cmd_ready=1 one cycle after release. Reset again mid NEXT k=10 -> no rsp_valid pulse, value=60'h1.
- **Step, value 60'h1:** NEXT k=1 -> rsp_valid 2 cycles after accept, value=60'h1234_4567_abcd, index=1, rsp_ok=1. NEXT k=0 -> rsp next cycle, value unchanged.
- **Wrap, value 60'h1:** PREV k=1 -> value=60'hFFF, index=2. NEXT k=4 -> rsp 5 cycles after accept, index=0, value=60'h1. Check intermediate indices 0,1,2,0 cycle by cycle.
- **Cast:** SET 60'h1234 -> rsp_ok=0, value unchanged. SET 60'h1 -> rsp_ok=1, index=0. SET 60'h1234_4567_abcd -> rsp_ok=1, index=1.
- **Force unknown:** FORCE 60'h11 -> value=60'h11, known=0, index=0, rsp_ok=0. Then NEXT k=7 -> rsp after 1 cycle, rsp_ok=0, value=60'h11. Then SET 60'hFFF -> known=1, index=2.
- **Generality:** WIDTH=96, COUNT=5, distinct codes differing only in bit 95 -> SET/NEXT/PREV correct. Back-to-back commands on consecutive cycles -> each receives exactly one response, in order.

Source files
------------

// File: rtl/enum_stepper.sv
// Enum value holder over a parameterised member table: cast, forced assignment, next(k)/prev(k) with wrap.
// One-cycle response for SET/FORCE/no-op steps; k-step walks take k+1 cycles, cmd_ready low while walking.
module enum_stepper #(
  parameter int WIDTH = 60,
  parameter int COUNT = 3,
  parameter logic [COUNT*WIDTH-1:0] CODES = {60'hFFF, 60'h1234_4567_abcd, 60'h1},
  parameter int STEPW = 8,
  parameter int IW = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] value,
  output logic [IW-1:0]    index,
  output logic             known,
  output logic             rsp_valid,
  output logic             rsp_ok
);

  typedef enum logic {IDLE, STEP} state_t;

  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_PREV  = 2'd2;
  localparam logic [1:0] OP_FORCE = 2'd3;

  state_t            state;
  logic              ready_q;
  logic              dir_prev;
  logic [STEPW-1:0]  rem;
  logic [WIDTH-1:0]  code_tab [COUNT];
  logic              hit;
  logic [IW-1:0]     hit_idx;
  logic [IW-1:0]     nxt_idx;
  logic [IW-1:0]     prv_idx;
  logic [IW-1:0]     step_idx;
  logic [STEPW-1:0]  k;

  for (genvar g = 0; g < COUNT; g++) begin : g_tab
    assign code_tab[g] = CODES[g*WIDTH +: WIDTH];
  end

  // Descending scan so the lowest matching index wins on duplicate codes.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = COUNT - 1; i >= 0; i--) begin
      if (code_tab[i] == cmd_arg) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign nxt_idx   = (index == IW'(COUNT - 1)) ? '0 : index + 1'b1;
  assign prv_idx   = (index == '0) ? IW'(COUNT - 1) : index - 1'b1;
  assign step_idx  = dir_prev ? prv_idx : nxt_idx;
  assign k         = cmd_arg[STEPW-1:0];
  assign cmd_ready = ready_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      value     <= code_tab[0];
      index     <= '0;
      known     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rem       <= '0;
      dir_prev  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && ready_q) begin
            case (cmd_op)
              OP_SET: begin
                rsp_valid <= 1'b1;
                rsp_ok    <= hit;
                if (hit) begin
                  value <= cmd_arg;
                  index <= hit_idx;
                  known <= 1'b1;
                end
              end
              OP_FORCE: begin
                value     <= cmd_arg;
                index     <= hit_idx;
                known     <= hit;
                rsp_valid <= 1'b1;
                rsp_ok    <= hit;
              end
              default: begin
                dir_prev <= (cmd_op == OP_PREV);
                if (known && k != '0) begin
                  state   <= STEP;
                  ready_q <= 1'b0;
                  rem     <= k;
                end else begin
                  rsp_valid <= 1'b1;
                  rsp_ok    <= known;
                end
              end
            endcase
          end
        end
        STEP: begin
          // One member per edge so intermediate values are observable.
          index <= step_idx;
          value <= code_tab[step_idx];
          rem   <= rem - 1'b1;
          if (rem == STEPW'(1)) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_ok    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enum_stepper.sv
// Scoreboarded random/directed bench for enum_stepper: default 60-bit/3-member table and a 96-bit/5-member table.
module tb_enum_stepper;

  localparam logic [59:0] E0 = 60'h1;
  localparam logic [59:0] E1 = 60'h1234_4567_abcd;
  localparam logic [59:0] E2 = 60'hFFF;
  localparam logic [95:0] D0 = 96'h5;
  localparam logic [95:0] D1 = {1'b1, 95'h5};
  localparam logic [95:0] D2 = 96'h7;
  localparam logic [95:0] D3 = {1'b1, 95'h7};
  localparam logic [95:0] D4 = 96'h1_0000_0000_0000_0000;

  typedef struct {
    logic [127:0] val;
    int           idx;
    bit           known;
    bit           ok;
    int           due;
  } exp_t;

  typedef struct {
    int idx;
    int due;
  } st_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
  logic        cmd_ready0, cmd_ready1;
  logic [1:0]  cmd_op0 = 2'd0, cmd_op1 = 2'd0;
  logic [59:0] cmd_arg0 = '0;
  logic [95:0] cmd_arg1 = '0;
  logic [59:0] value0;
  logic [95:0] value1;
  logic [1:0]  index0;
  logic [2:0]  index1;
  logic        known0, known1, rsp_valid0, rsp_valid1, rsp_ok0, rsp_ok1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] codes [2][5];
  logic [127:0] msk   [2];
  int           cnt   [2];
  logic [127:0] mval  [2];
  int           midx  [2];
  bit           mknown[2];
  exp_t         rq0[$];
  exp_t         rq1[$];
  st_t          stq[$];

  always #5 clk = ~clk;

  enum_stepper dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_op(cmd_op0), .cmd_arg(cmd_arg0), .value(value0), .index(index0),
    .known(known0), .rsp_valid(rsp_valid0), .rsp_ok(rsp_ok0)
  );

  enum_stepper #(.WIDTH(96), .COUNT(5), .CODES({D4, D3, D2, D1, D0}), .STEPW(8)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op1), .cmd_arg(cmd_arg1), .value(value1), .index(index1),
    .known(known1), .rsp_valid(rsp_valid1), .rsp_ok(rsp_ok1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic int lookup(input int u, input logic [127:0] a);
    for (int i = 0; i < cnt[u]; i++)
      if (codes[u][i] == a) return i;
    return -1;
  endfunction

  function automatic int wrap(input int u, input int i, input int d);
    return (((i + d) % cnt[u]) + cnt[u]) % cnt[u];
  endfunction

  // Reference: enum semantics computed directly from members and modular index arithmetic.
  task automatic predict(input int u, input logic [1:0] op, input logic [127:0] arg, output exp_t e);
    int m, k, lat, dir;
    logic [127:0] a;
    a   = arg & msk[u];
    lat = 1;
    m   = lookup(u, a);
    e.ok = 1'b0;
    case (op)
      2'd0: begin
        e.ok = (m >= 0);
        if (m >= 0) begin
          mval[u] = a; midx[u] = m; mknown[u] = 1'b1;
        end
      end
      2'd3: begin
        mval[u] = a; mknown[u] = (m >= 0); midx[u] = (m >= 0) ? m : 0; e.ok = (m >= 0);
      end
      default: begin
        k    = int'(a[7:0]);
        dir  = (op == 2'd1) ? 1 : -1;
        e.ok = mknown[u];
        if (mknown[u] && k > 0) begin
          if (u == 0)
            for (int j = 1; j <= k; j++) stq.push_back('{wrap(u, midx[u], dir * j), cyc + j + 1});
          midx[u] = wrap(u, midx[u], dir * k);
          mval[u] = codes[u][midx[u]];
          lat = k + 1;
        end
      end
    endcase
    e.val = mval[u]; e.idx = midx[u]; e.known = mknown[u]; e.due = cyc + lat;
  endtask

  task automatic issue0(input logic [1:0] op, input logic [127:0] arg);
    exp_t e;
    int n = 0;
    cmd_valid0 = 1'b1; cmd_op0 = op; cmd_arg0 = arg[59:0];
    while (!cmd_ready0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        fail_now("ready0_timeout");
        cmd_valid0 = 1'b0;
        return;
      end
    end
    @(posedge clk);
    predict(0, op, arg, e);
    rq0.push_back(e);
    @(negedge clk);
    cmd_valid0 = 1'b0;
  endtask

  task automatic issue1(input logic [1:0] op, input logic [127:0] arg);
    exp_t e;
    int n = 0;
    cmd_valid1 = 1'b1; cmd_op1 = op; cmd_arg1 = arg[95:0];
    while (!cmd_ready1) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        fail_now("ready1_timeout");
        cmd_valid1 = 1'b0;
        return;
      end
    end
    @(posedge clk);
    predict(1, op, arg, e);
    rq1.push_back(e);
    @(negedge clk);
    cmd_valid1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq0.delete(); rq1.delete(); stq.delete();
    for (int u = 0; u < 2; u++) begin
      mval[u] = codes[u][0]; midx[u] = 0; mknown[u] = 1'b1;
    end
    @(negedge clk);
    chk("ready_in_reset", cmd_ready0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_value", value0, E0);
    chk("rst_index", index0, 0);
    chk("rst_known", known0, 1);
    chk("rst_rsp_valid", rsp_valid0, 0);
    chk("rst_ready", cmd_ready0, 1);
    chk("rst_value96", value1, D0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    st_t  s;
    cyc++;
    if (rsp_valid0) begin
      if (rq0.size() == 0) fail_now("rsp0_unexpected");
      else begin
        e = rq0.pop_front();
        chk("rsp0_cycle", cyc, e.due);
        chk("rsp0_ok", rsp_ok0, e.ok);
        chk("rsp0_value", value0, e.val);
        chk("rsp0_index", index0, e.idx);
        chk("rsp0_known", known0, e.known);
      end
    end
    if (stq.size() > 0 && stq[0].due == cyc) begin
      s = stq.pop_front();
      chk("step_index", index0, s.idx);
    end
    if (known0) chk("member0", value0, codes[0][index0]);
    if (rsp_valid1) begin
      if (rq1.size() == 0) fail_now("rsp1_unexpected");
      else begin
        e = rq1.pop_front();
        chk("rsp1_cycle", cyc, e.due);
        chk("rsp1_ok", rsp_ok1, e.ok);
        chk("rsp1_value", value1, e.val);
        chk("rsp1_index", index1, e.idx);
        chk("rsp1_known", known1, e.known);
      end
    end
    if (known1 && int'(index1) < 5) chk("member1", value1, codes[1][int'(index1)]);
  end

  initial begin
    logic [127:0] r, arg;
    logic [1:0]   op;
    codes[0][0] = E0; codes[0][1] = E1; codes[0][2] = E2; codes[0][3] = '0; codes[0][4] = '0;
    codes[1][0] = D0; codes[1][1] = D1; codes[1][2] = D2; codes[1][3] = D3; codes[1][4] = D4;
    msk[0] = {68'h0, {60{1'b1}}};
    msk[1] = {32'h0, {96{1'b1}}};
    cnt[0] = 3; cnt[1] = 5;

    do_reset();

    // Directed sequence on the default table, issued back-to-back.
    issue0(2'd1, 128'd1);
    issue0(2'd1, 128'd0);
    issue0(2'd0, E0);
    issue0(2'd2, 128'd1);
    issue0(2'd1, 128'd4);
    issue0(2'd0, 128'h1234);
    issue0(2'd0, E0);
    issue0(2'd0, E1);
    issue0(2'd3, 128'h11);
    issue0(2'd1, 128'd7);
    issue0(2'd0, E2);
    issue0(2'd1, {120'hABCDEF, 8'd5});
    issue0(2'd0, E0);

    // Abort a 10-step walk with reset; no response may follow.
    issue0(2'd1, 128'd10);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (14) @(negedge clk);
    chk("abort_value", value0, E0);

    repeat (60) begin
      op  = 2'($urandom_range(0, 3));
      r   = {$urandom, $urandom, $urandom, $urandom};
      if (op == 2'd0 || op == 2'd3) arg = $urandom_range(0, 1) ? codes[0][$urandom_range(0, 2)] : r;
      else arg = {r[127:8], 8'($urandom_range(0, 8))};
      issue0(op, arg);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Wide table: members differ only in bit 95 pairwise, one lives above bit 63.
    issue1(2'd0, D3);
    issue1(2'd1, 128'd3);
    issue1(2'd2, 128'd7);
    issue1(2'd0, D0 | (96'h1 << 94));
    issue1(2'd0, D1);
    issue1(2'd3, D0);
    issue1(2'd2, 128'd1);
    repeat (40) begin
      op  = 2'($urandom_range(0, 3));
      r   = {$urandom, $urandom, $urandom, $urandom};
      if (op == 2'd0 || op == 2'd3) arg = $urandom_range(0, 1) ? codes[1][$urandom_range(0, 4)] : r;
      else arg = {r[127:8], 8'($urandom_range(0, 12))};
      issue1(op, arg);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    repeat (30) @(negedge clk);
    chk("rq0_drained", rq0.size(), 0);
    chk("rq1_drained", rq1.size(), 0);
    chk("steps_drained", stq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
